mul_err_stats: RTL
==================

Name: mul_err_stats

Overview:
- Streaming error-characterisation stage that sits directly downstream of an approximate 8x8 unsigned multiplier.
- Accepts operand pairs together with the approximate product, computes the exact product internally and accumulates error metrics over a run of N samples:
  - sum of absolute error (for MAE)
  - worst-case error (WCE) and the operands that produced it
  - count of erroneous samples (for EP)
- Used on-FPGA to characterise approximate multipliers without host-side recomputation.

Parameters:
- W, 8, operand width; products are 2W bits.
- CNT_W, 17, sample counter width; covers the exhaustive 2^16 sweep.
- ACC_W, 33, error-sum accumulator width; default is CNT_W+2W and cannot overflow.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse; clears stats and begins a run
- num_samples  in  CNT_W  run length N; sampled on the accepted start
- in_valid  in  1  sample valid
- in_ready  out  1  stage can accept a sample
- a  in  W  operand A
- b  in  W  operand B
- o_apx  in  2W  approximate product under test
- busy  out  1  run in progress (RUN or DRAIN)
- done  out  1  stats final and stable
- sample_cnt  out  CNT_W  samples accumulated
- err_sum  out  ACC_W  sum of abs(a*b - o_apx)
- err_max  out  2W  worst-case abs error
- err_cnt  out  CNT_W  samples with nonzero error
- wc_a  out  W  operand A of the worst case
- wc_b  out  W  operand B of the worst case

Behaviour:
- One clock domain, clk. Reset is synchronous, active-high on rst.
- Reset values:
  - state = IDLE.
  - All stat outputs, wc_a, wc_b and the pipeline valid bits = 0.
  - in_ready = 0, busy = 0, done = 0.
- State machine:
  - IDLE -> RUN on start. start also clears all stats and latches N.
  - RUN: in_ready = 1 while accepted < N. A sample transfers when in_valid & in_ready. When accepted == N, go to DRAIN.
  - DRAIN: in_ready = 0. Go to DONE when all pipeline valid bits are 0.
  - DONE: done = 1, stats held. start -> RUN with a fresh clear, same cycle semantics as from IDLE.
  - start is ignored in RUN and DRAIN.
- N = 0: start moves to RUN; RUN sees accepted == N and moves to DRAIN next cycle, then DONE. All stats stay 0.
- Pipeline: 3 registered stages, fixed latency 3 cycles from the transfer cycle to the stat update.
  - S1: register a, b, o_apx and valid.
  - S2: exact product p = a*b (2W bits, unsigned); carry o_apx, a, b.
  - S3: e = |p - o_apx| (2W bits; the comparison selects the subtraction order).
- Accumulate on S3 valid:
  - sample_cnt += 1.
  - err_sum += e, saturating at all-ones if ACC_W is overridden smaller.
  - err_cnt += (e != 0).
  - If e > err_max (strictly greater): update err_max, wc_a, wc_b. Ties keep the first occurrence.
- Bubbles (in_valid low) insert empty slots; throughput is 1 sample/clk.
- in_valid while in_ready = 0 is dropped; the source must hold per valid/ready.
- rst mid-run aborts immediately: pipeline flushed, stats cleared, IDLE.

Optional Feature:
- Macro: MUL_ERR_STATS_MSE_EN.
- Defined:
  - Adds output err_sq_sum (2*2W + CNT_W bits), the sum of e*e.
  - The square is computed in an extra S4 stage, giving latency 4; all stats update together at S4.
  - DRAIN waits for S4 to empty.
- Undefined:
  - Port absent, latency 3, no squarer logic.

Decomposition:
- Package mul_err_stats_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the default widths W = 8, CNT_W = 17, ACC_W = 33.
- Sub-module abs_diff: unsigned 2W-bit |x - y|, combinational, instantiated in S3 and reusable by sibling stats blocks.

Test Plan:
- Exhaustive sweep, N = 65536, o_apx = a*b exactly. Required at done: sample_cnt = 65536, err_sum = 0, err_max = 0, err_cnt = 0.
- N = 3, samples (200,200,0), (1,1,2), (15,15,225). Required: err_sum = 40001, err_max = 40000, wc_a = wc_b = 200, err_cnt = 2.
- Tie case, N = 2, samples (4,4,10) then (3,3,15). Both have e = 6; required: wc_a = wc_b = 4 (first occurrence kept).
- N = 0 start. Required: done asserts within 3 cycles, all stats 0, in_ready never 1.
- in_valid toggled every other cycle with N = 5, and rst pulsed after 3 transfers. Required: stats cleared, state IDLE. A new start with N = 5 then completes with sample_cnt = 5.
- With MUL_ERR_STATS_MSE_EN defined, N = 2, samples (10,10,90) and (2,3,8). Required: err_sq_sum = 100 + 4 = 104, done asserts 4 cycles after the last transfer.

Source files
------------

// File: rtl/mul_err_stats_pkg.sv
// rtl/mul_err_stats_pkg.sv - shared state encoding and default widths for mul_err_stats
package mul_err_stats_pkg;
  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 17;
  localparam int ACC_W_DEF = 33;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/abs_diff.sv
// rtl/abs_diff.sv - combinational unsigned |x - y|
module abs_diff #(
  parameter int PW = 16
) (
  input  logic [PW-1:0] x,
  input  logic [PW-1:0] y,
  output logic [PW-1:0] d
);
  assign d = (x >= y) ? (x - y) : (y - x);
endmodule

// File: rtl/mul_err_stats.sv
// rtl/mul_err_stats.sv - error statistics (MAE/WCE/EP) for an approximate 8x8 multiplier
// Optional MUL_ERR_STATS_MSE_EN adds err_sq_sum via an extra squaring stage.
module mul_err_stats
  import mul_err_stats_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [2*W-1:0]     o_apx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [ACC_W-1:0]   err_sum,
  output logic [2*W-1:0]     err_max,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [W-1:0]       wc_a,
`ifdef MUL_ERR_STATS_MSE_EN
  output logic [4*W+CNT_W-1:0] err_sq_sum,
`endif
  output logic [W-1:0]       wc_b
);
  localparam int PW = 2 * W;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] n_lat, accepted;
  logic             xfer, clear, pipe_busy;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        busy     = 1'b1;
        in_ready = (accepted < n_lat);
        if (accepted == n_lat) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!pipe_busy) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = RUN;
      end
    endcase
  end

  assign xfer  = in_valid & in_ready;
  assign clear = start & ((state == IDLE) | (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_lat    <= '0;
      accepted <= '0;
    end else begin
      state <= state_nx;
      if (clear) begin
        n_lat    <= num_samples;
        accepted <= '0;
      end else if (xfer) begin
        accepted <= accepted + CNT_W'(1);
      end
    end
  end

  // Data registers need no reset; only the valid bits gate accumulation.
  logic          s1_v, s2_v;
  logic [W-1:0]  s1_a, s1_b, s2_a, s2_b;
  logic [PW-1:0] s1_apx, s2_apx, s2_p, s2_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= xfer;
      s2_v <= s1_v;
    end
    s1_a   <= a;
    s1_b   <= b;
    s1_apx <= o_apx;
    s2_a   <= s1_a;
    s2_b   <= s1_b;
    s2_apx <= s1_apx;
    s2_p   <= PW'(s1_a) * PW'(s1_b);
  end

  abs_diff #(.PW(PW)) u_abs_diff (.x(s2_p), .y(s2_apx), .d(s2_e));

  logic          upd_v;
  logic [PW-1:0] upd_e;
  logic [W-1:0]  upd_a, upd_b;

`ifdef MUL_ERR_STATS_MSE_EN
  localparam int SQW = 4 * W + CNT_W;
  logic          s3_v;
  logic [PW-1:0] s3_e;
  logic [W-1:0]  s3_a, s3_b;
  logic [SQW-1:0] sq;

  always_ff @(posedge clk) begin
    if (rst) s3_v <= 1'b0;
    else     s3_v <= s2_v;
    s3_e <= s2_e;
    s3_a <= s2_a;
    s3_b <= s2_b;
  end

  assign sq        = SQW'(s3_e) * SQW'(s3_e);
  assign upd_v     = s3_v;
  assign upd_e     = s3_e;
  assign upd_a     = s3_a;
  assign upd_b     = s3_b;
  assign pipe_busy = s1_v | s2_v | s3_v;

  always_ff @(posedge clk) begin
    if (rst || clear) err_sq_sum <= '0;
    else if (upd_v)   err_sq_sum <= err_sq_sum + sq;
  end
`else
  assign upd_v     = s2_v;
  assign upd_e     = s2_e;
  assign upd_a     = s2_a;
  assign upd_b     = s2_b;
  assign pipe_busy = s1_v | s2_v;
`endif

  // Widened add so a narrowed ACC_W saturates instead of wrapping.
  logic [SW-1:0] sum_ext;
  logic          sum_sat;
  assign sum_ext = SW'(err_sum) + SW'(upd_e);
  assign sum_sat = sum_ext > SW'({ACC_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_cnt <= '0;
      err_sum    <= '0;
      err_max    <= '0;
      err_cnt    <= '0;
      wc_a       <= '0;
      wc_b       <= '0;
    end else if (upd_v) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      err_sum    <= sum_sat ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      err_cnt    <= err_cnt + CNT_W'(upd_e != '0);
      if (upd_e > err_max) begin
        err_max <= upd_e;
        wc_a    <= upd_a;
        wc_b    <= upd_b;
      end
    end
  end
endmodule
